// File: rtl/skinny_inv_sbox8_dom1_iter.sv
// First-order DOM-masked inverse SKINNY-128 8-bit S-box.
// One masked NOR-XOR layer runs every two cycles: cross terms are registered first, then the layer is applied.
module skinny_inv_sbox8_dom1_iter (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] si_0,
    input  logic [7:0] si_1,
    input  logic [7:0] r,
    output logic       busy,
    output logic       done,
    output logic [7:0] so_0,
    output logic [7:0] so_1
);

    localparam int unsigned W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CROSS  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t         state;
    logic [1:0]     lc;
    logic [W-1:0]   s0;
    logic [W-1:0]   s1;
    logic [W-1:0]   rr;
    logic [3:0]     cross_q;

    // Final forward swap of bits 1 and 2 (self-inverse).
    function automatic logic [W-1:0] swap12(input logic [W-1:0] x);
        swap12 = {x[7:3], x[1], x[2], x[0]};
    endfunction

    // Inverse of the SKINNY 8-bit wiring permutation.
    function automatic logic [W-1:0] inv_perm(input logic [W-1:0] y);
        inv_perm = {y[5], y[4], y[0], y[3], y[1], y[7], y[6], y[2]};
    endfunction

    // NOR operands: share 0 complemented so that an AND of shares yields the NOR.
    logic a0h, b0h, a1h, b1h;
    logic a0l, b0l, a1l, b1l;
    logic rk_h, rk_l;
    logic [3:0]   cross_d;
    logic [W-1:0] n0;
    logic [W-1:0] n1;

    always_comb begin
        a0h     = ~s0[7];
        b0h     = ~s0[6];
        a1h     = s1[7];
        b1h     = s1[6];
        a0l     = ~s0[3];
        b0l     = ~s0[2];
        a1l     = s1[3];
        b1l     = s1[2];
        rk_h    = rr[{lc, 1'b0}];
        rk_l    = rr[{lc, 1'b1}];
        cross_d = {(a1h & b0h) ^ rk_h, (a0h & b1h) ^ rk_h,
                   (a1l & b0l) ^ rk_l, (a0l & b1l) ^ rk_l};
        n0      = s0;
        n1      = s1;
        n0[4]   = s0[4] ^ (a0h & b0h) ^ cross_q[2];
        n0[0]   = s0[0] ^ (a0l & b0l) ^ cross_q[0];
        n1[4]   = s1[4] ^ (a1h & b1h) ^ cross_q[3];
        n1[0]   = s1[0] ^ (a1l & b1l) ^ cross_q[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lc      <= 2'd0;
            s0      <= '0;
            s1      <= '0;
            rr      <= '0;
            cross_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            so_0    <= '0;
            so_1    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        s0    <= swap12(si_0);
                        s1    <= swap12(si_1);
                        rr    <= r;
                        lc    <= 2'd0;
                        busy  <= 1'b1;
                        state <= CROSS;
                    end
                end
                CROSS: begin
                    cross_q <= cross_d;
                    state   <= UPDATE;
                end
                UPDATE: begin
                    if (lc == 2'd3) begin
                        s0    <= n0;
                        s1    <= n1;
                        so_0  <= n0;
                        so_1  <= n1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        s0    <= inv_perm(n0);
                        s1    <= inv_perm(n1);
                        lc    <= lc + 2'd1;
                        state <= CROSS;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_skinny_inv_sbox8_dom1_iter.sv
// Directed bench for the masked inverse SKINNY 8-bit S-box: function, latency, handshake, reset and hold.
module tb_skinny_inv_sbox8_dom1_iter;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] si_0;
    logic [7:0] si_1;
    logic [7:0] r;
    logic       busy;
    logic       done;
    logic [7:0] so_0;
    logic [7:0] so_1;

    int n_vec = 0;
    int n_err = 0;

    skinny_inv_sbox8_dom1_iter dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .si_0 (si_0),
        .si_1 (si_1),
        .r    (r),
        .busy (busy),
        .done (done),
        .so_0 (so_0),
        .so_1 (so_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Forward S8 written from the reference shift/mask form.
    function automatic logic [7:0] sb_mix(input logic [7:0] x);
        logic [7:0] t;
        t = ((x >> 1) | x) >> 2;
        return x ^ (~t & 8'h11);
    endfunction

    function automatic logic [7:0] sb_perm(input logic [7:0] x);
        return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
               ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
    endfunction

    function automatic logic [7:0] sb_swap(input logic [7:0] x);
        return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] y;
        y = sb_mix(x);
        y = sb_perm(y);
        y = sb_mix(y);
        y = sb_perm(y);
        y = sb_mix(y);
        y = sb_perm(y);
        y = sb_mix(y);
        return sb_swap(y);
    endfunction

    // Called at posedge+1; returns at posedge+1 of the done cycle (or after a timeout).
    // lat counts clock edges from start assertion up to and including the edge that raises done.
    task automatic run_op(input logic [7:0] x, input logic [7:0] m, input logic [7:0] rv,
                          input int intr_cyc, input logic [7:0] ix,
                          output logic [7:0] y0, output logic [7:0] y1, output int lat);
        si_0  = x ^ m;
        si_1  = m;
        r     = rv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            if (lat == intr_cyc) begin
                si_0  = ix;
                si_1  = 8'h00;
                r     = ~rv;
                start = 1'b1;
            end else begin
                si_0  = 8'($urandom);
                si_1  = 8'($urandom);
                r     = 8'($urandom);
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        y0    = so_0;
        y1    = so_1;
    endtask

    logic [7:0] y0, y1, y0a, y1a, y0b, y1b, y0c, y1c, h0, h1;
    int         lat;
    int         nd;
    int         nchg;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        si_0  = 8'h00;
        si_1  = 8'h00;
        r     = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_so0", 32'(so_0), 32'h0);
        check("rst_so1", 32'(so_1), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Hand-known points of the inverse table
        run_op(8'h65, 8'h3C, 8'h96, 0, 8'h00, y0, y1, lat);
        check("inv65", 32'(y0 ^ y1), 32'h00);
        check("lat65", 32'(lat), 32'd9);
        check("done65", 32'(done), 32'h1);
        check("busy_in_done", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'h0);
        run_op(8'h00, 8'hC5, 8'h21, 0, 8'h00, y0, y1, lat);
        check("inv00", 32'(y0 ^ y1), 32'hAC);

        // Exhaustive sweep with random masks and randomness
        for (int x = 0; x < 256; x++) begin
            run_op(8'(x), 8'($urandom), 8'($urandom), 0, 8'h00, y0, y1, lat);
            check("exh_val", 32'(sbox_fwd(y0 ^ y1)), 32'(x));
            check("exh_lat", 32'(lat), 32'd9);
        end

        // Mask / randomness independence
        run_op(8'hA7, 8'h00, 8'h00, 0, 8'h00, y0a, y1a, lat);
        run_op(8'hA7, 8'hFF, 8'hFF, 0, 8'h00, y0b, y1b, lat);
        run_op(8'hA7, 8'h5A, 8'hC3, 0, 8'h00, y0c, y1c, lat);
        check("mask_a", 32'(sbox_fwd(y0a ^ y1a)), 32'hA7);
        check("mask_ab", 32'(y0a ^ y1a), 32'(y0b ^ y1b));
        check("mask_ac", 32'(y0a ^ y1a), 32'(y0c ^ y1c));
        check("mask_so0_varies", 32'((y0b != y0a) || (y0c != y0a)), 32'h1);

        // Start while busy is ignored
        run_op(8'h3D, 8'h81, 8'h4E, 3, 8'h12, y0, y1, lat);
        check("busy_start_val", 32'(sbox_fwd(y0 ^ y1)), 32'h3D);
        check("busy_start_lat", 32'(lat), 32'd9);
        nd = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("busy_start_ndone", 32'(nd), 32'd0);

        // Back-to-back: new start in the done cycle
        run_op(8'h5B, 8'h77, 8'h0F, 0, 8'h00, y0, y1, lat);
        check("b2b_first", 32'(sbox_fwd(y0 ^ y1)), 32'h5B);
        run_op(8'hE4, 8'h19, 8'hA2, 0, 8'h00, y0, y1, lat);
        check("b2b_second", 32'(sbox_fwd(y0 ^ y1)), 32'hE4);
        check("b2b_lat", 32'(lat), 32'd9);

        // Output hold without start
        h0 = so_0;
        h1 = so_1;
        nchg = 0;
        nd   = 0;
        repeat (20) begin
            si_0 = 8'($urandom);
            si_1 = 8'($urandom);
            r    = 8'($urandom);
            @(posedge clk);
            #1;
            if (so_0 !== h0 || so_1 !== h1) nchg++;
            if (done) nd++;
        end
        check("hold_changes", 32'(nchg), 32'd0);
        check("hold_done", 32'(nd), 32'd0);

        // Reset in the middle of an operation
        si_0  = 8'h9E;
        si_1  = 8'h44;
        r     = 8'h5C;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_so0", 32'(so_0), 32'h0);
        check("midrst_so1", 32'(so_1), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        nd = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("midrst_ndone", 32'(nd), 32'd0);
        check("midrst_idle_busy", 32'(busy), 32'h0);
        run_op(8'hC8, 8'h2B, 8'h90, 0, 8'h00, y0, y1, lat);
        check("post_rst_val", 32'(sbox_fwd(y0 ^ y1)), 32'hC8);
        check("post_rst_lat", 32'(lat), 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
